// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter with terminal-count pulse.
// Counts from a programmed value toward zero in RUN. It offers
// one-shot and auto-reload modes, so it can serve as a delay or
// period timer. Reset is synchronous and active-low.
// Optional feature macro: SYNC_DOWN_PRESCALE_EN. When this macro is
// defined, a prescaler divides the decrement rate by PRESCALE.
module sync_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] start_val;
  logic             tick;

`ifdef SYNC_DOWN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre, pre_nxt;

  // A tick fires on the last prescaler phase of each PRESCALE-clock window.
  assign tick = (pre == PW'(PRESCALE - 1));
`else
  localparam int TICK_DIV = (PRESCALE > 0) ? 1 : 1;

  // Without the prescaler, every clock spent in RUN is a tick.
  assign tick = (TICK_DIV == 1);
`endif

  // Starting from IDLE uses the held count; from RUN or DONE it restarts from reload.
  assign start_val = (state == IDLE) ? count : reload;

  // Registered state update; reset wins over every other control at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '1;
      reload <= '1;
      tc     <= 1'b0;
`ifdef SYNC_DOWN_PRESCALE_EN
      pre    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
`ifdef SYNC_DOWN_PRESCALE_EN
      pre    <= pre_nxt;
`endif
    end
  end

  // Next-state logic with priority load > stop > start > tick; tc defaults low so it only pulses.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
`ifdef SYNC_DOWN_PRESCALE_EN
    pre_nxt    = pre;
`endif
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
`ifdef SYNC_DOWN_PRESCALE_EN
      pre_nxt    = '0;
`endif
    end else if (stop) begin
      if (state == RUN) begin
        state_nxt = IDLE;
      end
`ifdef SYNC_DOWN_PRESCALE_EN
      pre_nxt = '0;
`endif
    end else if (start) begin
      count_nxt = start_val;
`ifdef SYNC_DOWN_PRESCALE_EN
      pre_nxt   = '0;
`endif
      if (start_val != '0) begin
        state_nxt = RUN;
      end else if (auto_reload) begin
        // A zero period in auto-reload mode fires tc on every tick.
        state_nxt = RUN;
        tc_nxt    = 1'b1;
      end else begin
        state_nxt = DONE;
        tc_nxt    = 1'b1;
      end
    end else if (state == RUN) begin
`ifdef SYNC_DOWN_PRESCALE_EN
      pre_nxt = tick ? '0 : pre + PW'(1);
`endif
      if (tick) begin
        if (count > WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
        end else if (count == WIDTH'(1)) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
          if (!auto_reload) begin
            state_nxt = DONE;
          end
        end else begin
          count_nxt = reload;
          tc_nxt    = (reload == '0);
        end
      end
    end
  end

  // Status flags are plain decodes of the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
